// File: rtl/sr_ff_bank.sv
// sr_ff_bank: clocked bank of CH independent set/reset cells.
// S=R=1 is resolved by the static MODE parameter and each such event is
// captured in a sticky per-channel flag and a saturating cycle counter.
module sr_ff_bank #(
   parameter int             CH      = 8,
   parameter int             MODE    = 0,
   parameter int             CNT_W   = 4,
   parameter logic [CH-1:0]  RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [CH-1:0]    s,
   input  logic [CH-1:0]    r,
   input  logic             load,
   input  logic [CH-1:0]    load_val,
   input  logic             clr_err,
   output logic [CH-1:0]    q,
   output logic [CH-1:0]    qb,
   output logic [CH-1:0]    err,
   output logic             any_err,
   output logic [CNT_W-1:0] err_cnt
);

   // Out-of-range MODE values fall back to hold.
   localparam int MODE_EFF = (MODE >= 0 && MODE <= 3) ? MODE : 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CH-1:0]    q_q,   q_d;
   logic [CH-1:0]    err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CH-1:0]    conf;

   // Conflict resolution for one channel given its current state.
   function automatic logic resolve(input logic cur);
      case (MODE_EFF)
         0:       return 1'b0;
         1:       return 1'b1;
         3:       return ~cur;
         default: return cur;
      endcase
   endfunction

   // Next-state: load beats enable-hold beats s/r; clr_err applies first so a
   // same-cycle conflict still lands in err/err_cnt.
   always_comb begin
      conf  = s & r;
      q_d   = q_q;
      err_d = err_q;
      cnt_d = cnt_q;
      if (clr_err) begin
         err_d = '0;
         cnt_d = '0;
      end
      if (load) begin
         q_d = load_val;
      end else if (en) begin
         for (int i = 0; i < CH; i++) begin
            case ({s[i], r[i]})
               2'b01:   q_d[i] = 1'b0;
               2'b10:   q_d[i] = 1'b1;
               2'b11:   q_d[i] = resolve(q_q[i]);
               default: q_d[i] = q_q[i];
            endcase
         end
         err_d = err_d | conf;
         if ((|conf) && (cnt_d != CNT_MAX)) begin
            cnt_d = cnt_d + 1'b1;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q   <= RST_VAL;
         err_q <= '0;
         cnt_q <= '0;
      end else begin
         q_q   <= q_d;
         err_q <= err_d;
         cnt_q <= cnt_d;
      end
   end

   assign q       = q_q;
   assign qb      = ~q_q;
   assign err     = err_q;
   assign any_err = |err_q;
   assign err_cnt = cnt_q;

endmodule

// File: doc/sr_ff_bank.md
Name: sr_ff_bank

Overview:
- Parametrised, clocked bank of CH independent set/reset storage cells. This is the synchronous, multi-channel successor to the team's single-bit SR latch.
- Resolves the S=R=1 condition deterministically through a selectable mode instead of driving high-impedance.
- Flags conflicts in sticky per-channel error bits and counts them in a saturating counter.
- Sits in control/status paths: interrupt pending bits, fault capture, mode flags.

Parameters:
- CH, 8, number of independent SR channels (1..32).
- MODE, 0, S=R=1 resolution: 0 reset-dominant (q<=0), 1 set-dominant (q<=1), 2 hold (q unchanged), 3 toggle (q<=~q).
- CNT_W, 4, width of the saturating conflict counter (2..16).
- RST_VAL, 0, CH-bit value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  update enable; when low, q holds and no conflict is recorded
- s  input  CH  per-channel set request
- r  input  CH  per-channel reset request
- load  input  1  synchronous parallel load strobe
- load_val  input  CH  value written to q when load=1
- clr_err  input  1  synchronous clear of err and err_cnt
- q  output  CH  registered channel state
- qb  output  CH  bitwise complement of q
- err  output  CH  sticky per-channel conflict flag
- any_err  output  1  OR-reduction of err
- err_cnt  output  CNT_W  saturating count of cycles containing at least one recorded conflict

Behaviour:
- Reset (rst_n=0, asynchronous, independent of clk):
  - q=RST_VAL, qb=~RST_VAL.
  - err=0, any_err=0, err_cnt=0.
  - Outputs hold these values while rst_n is low.
  - First update occurs on the first rising edge after rst_n deasserts.
- All state updates happen on the rising edge of clk. Latency is 1 cycle from inputs to q.
- qb is combinationally ~q at all times. Never X or Z after reset.
- Priority per edge, highest first: load > en=0 (hold) > s/r evaluation.
- load=1: q<=load_val regardless of en, s, r. No conflict is recorded that cycle, and err/err_cnt change only through clr_err.
- load=0, en=0: q holds; err and err_cnt change only through clr_err.
- load=0, en=1, evaluated per channel i:
  - s=0, r=0: hold.
  - s=0, r=1: q[i]<=0.
  - s=1, r=0: q[i]<=1.
  - s=1, r=1: resolved per MODE, and the conflict is recorded for channel i.
- Conflict recording (load=0, en=1, with c = s&r):
  - err <= (clr_err ? 0 : err) | c. A new conflict wins over a same-cycle clear.
  - If c is nonzero, err_cnt <= (clr_err ? 0 : err_cnt) + 1, saturating at 2^CNT_W-1. Multiple conflicting channels in one cycle count once.
  - If c is zero, err_cnt <= clr_err ? 0 : err_cnt.
- clr_err acts in any cycle, including when load=1 or en=0.
- Saturation: err_cnt stays at 2^CNT_W-1 until clr_err or reset. It never wraps.
- any_err is combinational from err and asserts in the same cycle err is visible.
- Reset mid-operation: asynchronous rst_n overrides a pending load, clr_err or conflict immediately. Nothing is retained.
- MODE is static. An illegal MODE value (outside 0..3) behaves as 2 (hold).

Test Plan:
- Reset/basic, CH=8, RST_VAL=8'hA5: hold rst_n=0 -> q=A5, qb=5A, err=0, err_cnt=0. Release, en=1, s=8'h0F, r=8'hF0 -> next edge q=0F, qb=F0, err=00.
- Conflict modes: start q=8'h55, en=1, s=r=8'h03, one edge.
  - MODE0 -> q=54.
  - MODE1 -> q=57.
  - MODE2 -> q=55.
  - MODE3 -> q=56.
  - All modes -> err=03, any_err=1, err_cnt=1.
- Enable/load priority:
  - en=0, s=FF, r=00 -> q unchanged, no err.
  - load=1, load_val=3C, s=r=FF, en=1 -> q=3C, err unchanged, err_cnt unchanged.
- Clear vs new conflict: err=01, err_cnt=5. Apply clr_err=1 with s=r=8'h80, en=1 -> err=80, err_cnt=1. Next cycle clr_err=1 only -> err=00, err_cnt=0.
- Saturation, CNT_W=4: 20 consecutive conflict cycles -> err_cnt stops at 15 and holds; clr_err -> 0.
- Async reset mid-operation: assert rst_n=0 between clock edges during a toggle stream -> q=RST_VAL and err_cnt=0 immediately, before the next edge.
